// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : debounce_multi
// Description : Multi-channel run-length debouncer. Each channel accepts a
//               new level only after the raw input has differed from the
//               current output for HI_TH (rising) or LO_TH (falling)
//               consecutive cycles. It produces one-cycle rise/fall pulses on
//               accepted changes and a glitch pulse when a candidate run is
//               abandoned before reaching its threshold.
//               Optional macro DEBOUNCE_SYNC_EN inserts a 2-flop synchroniser
//               per channel ahead of the filter, adding 2 cycles of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_multi #(
    parameter int   CH    = 4,
    parameter int   CNT_W = 4,
    parameter int   HI_TH = 4,
    parameter int   LO_TH = 4,
    parameter logic INIT  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] in,
    output logic [CH-1:0] out,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [CH-1:0] glitch
);

    // Terminal counts; one extra bit so a threshold of 2^CNT_W still fits.
    localparam logic [CNT_W:0] c_hi_m1 = (CNT_W+1)'(HI_TH - 1);
    localparam logic [CNT_W:0] c_lo_m1 = (CNT_W+1)'(LO_TH - 1);
    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CH-1:0] w_s;

`ifdef DEBOUNCE_SYNC_EN
    logic [CH-1:0] r_sync1;
    logic [CH-1:0] r_sync2;

    // Two-stage synchroniser; preset to INIT so reset release looks quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= {CH{INIT}};
            r_sync2 <= {CH{INIT}};
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = in;
`endif

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic             r_out;
            logic             r_rise;
            logic             r_fall;
            logic             r_glitch;
            logic [CNT_W:0]   w_th_m1;
            logic             w_at_th;

            // Threshold follows the direction the sample is trying to move to.
            assign w_th_m1 = w_s[i] ? c_hi_m1 : c_lo_m1;
            assign w_at_th = ({1'b0, r_cnt} == w_th_m1);

            // Per-channel run-length filter with registered event pulses.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt    <= '0;
                    r_out    <= INIT;
                    r_rise   <= 1'b0;
                    r_fall   <= 1'b0;
                    r_glitch <= 1'b0;
                end else begin
                    r_rise   <= 1'b0;
                    r_fall   <= 1'b0;
                    r_glitch <= 1'b0;
                    if (w_s[i] == r_out) begin
                        // A non-zero count here means a run was abandoned.
                        r_glitch <= (r_cnt != '0);
                        r_cnt    <= '0;
                    end else if (w_at_th) begin
                        r_out  <= w_s[i];
                        r_rise <= w_s[i];
                        r_fall <= ~w_s[i];
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
            end

            assign out[i]    = r_out;
            assign rise[i]   = r_rise;
            assign fall[i]   = r_fall;
            assign glitch[i] = r_glitch;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_multi
// Description : Self-checking bench for debounce_multi (CH=4, HI_TH=4,
//               LO_TH=6, INIT=1). Honors DEBOUNCE_SYNC_EN for the DUT build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_multi;

    localparam int   CH    = 4;
    localparam int   HI_TH = 4;
    localparam int   LO_TH = 6;
    localparam logic INIT  = 1'b1;
`ifdef DEBOUNCE_SYNC_EN
    localparam int   LAT   = 2;
`else
    localparam int   LAT   = 0;
`endif

    typedef struct packed {
        logic [CH-1:0] out;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic [CH-1:0] glitch;
    } exp_t;

    typedef struct packed {
        logic          rst;
        logic [CH-1:0] in;
        exp_t          exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] in  = {CH{1'b1}};
    logic [CH-1:0] out, rise, fall, glitch;

    int checks = 0;
    int errors = 0;

    exp_t sb_q[$];

    // Reference model state: run length of the current differing stretch.
    logic [CH-1:0] m_out;
    int            m_run [CH];
    logic [CH-1:0] m_s1, m_s2;

    debounce_multi #(
        .CH(CH), .CNT_W(4), .HI_TH(HI_TH), .LO_TH(LO_TH), .INIT(INIT)
    ) dut (
        .clk(clk), .rst(rst), .in(in),
        .out(out), .rise(rise), .fall(fall), .glitch(glitch)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic r, input logic [CH-1:0] v, output exp_t e);
        logic [CH-1:0] s;
        e = '0;
        if (r) begin
            m_out = {CH{INIT}};
            m_s1  = {CH{INIT}};
            m_s2  = {CH{INIT}};
            for (int i = 0; i < CH; i++) m_run[i] = 0;
        end else begin
            if (LAT == 2) begin
                s    = m_s2;
                m_s2 = m_s1;
                m_s1 = v;
            end else begin
                s = v;
            end
            for (int i = 0; i < CH; i++) begin
                if (s[i] == m_out[i]) begin
                    e.glitch[i] = (m_run[i] > 0);
                    m_run[i]    = 0;
                end else begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] >= (s[i] ? HI_TH : LO_TH)) begin
                        m_out[i]  = s[i];
                        e.rise[i] = s[i];
                        e.fall[i] = ~s[i];
                        m_run[i]  = 0;
                    end
                end
            end
        end
        e.out = m_out;
    endtask

    task automatic compare(input string name);
        exp_t e, a;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got out=%h", name, out);
        end else begin
            e = sb_q.pop_front();
            a = '{out: out, rise: rise, fall: fall, glitch: glitch};
            if (a !== e) begin
                errors++;
                $display("FAIL %s @%0t: got out=%h rise=%h fall=%h glitch=%h, expected out=%h rise=%h fall=%h glitch=%h",
                         name, $time, a.out, a.rise, a.fall, a.glitch,
                         e.out, e.rise, e.fall, e.glitch);
            end
        end
    endtask

    // Drive one cycle; expected result comes from the model unless overridden.
    task automatic step(input logic r, input logic [CH-1:0] v, input string name,
                        input logic use_ovr = 1'b0, input exp_t ovr = '0);
        exp_t e;
        @(negedge clk);
        rst = r;
        in  = v;
        model_step(r, v, e);
        sb_q.push_back(use_ovr ? ovr : e);
        @(posedge clk);
        #1;
        compare(name);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Holds ch with a low input (others high) and reports the edge at which fall[ch] fired.
    task automatic count_fall(input int ch, input string name, output int edge_n);
        logic [CH-1:0] v;
        v = {CH{1'b1}};
        v[ch] = 1'b0;
        edge_n = -1;
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, v, name);
            if (fall[ch] && edge_n < 0) edge_n = k;
            if (edge_n > 0) k = 21;
        end
    endtask

    vec_t tbl [22];

    initial begin
        int n_gl, n_ri, e_n;
        logic [CH-1:0] v;

        // Reset, then channel 0: full low run, then a 5-cycle low run that is rejected.
        tbl[0]  = '{1'b1, 4'hF, '{4'hF, 4'h0, 4'h0, 4'h0}};
        tbl[1]  = '{1'b1, 4'hF, '{4'hF, 4'h0, 4'h0, 4'h0}};
        tbl[2]  = '{1'b1, 4'hF, '{4'hF, 4'h0, 4'h0, 4'h0}};
        tbl[3]  = '{1'b0, 4'hF, '{4'hF, 4'h0, 4'h0, 4'h0}};
        for (int k = 4; k <= 8; k++) tbl[k] = '{1'b0, 4'hE, '{4'hF, 4'h0, 4'h0, 4'h0}};
        tbl[9]  = '{1'b0, 4'hE, '{4'hE, 4'h0, 4'h1, 4'h0}};
        tbl[10] = '{1'b0, 4'hE, '{4'hE, 4'h0, 4'h0, 4'h0}};
        for (int k = 11; k <= 13; k++) tbl[k] = '{1'b0, 4'hF, '{4'hE, 4'h0, 4'h0, 4'h0}};
        tbl[14] = '{1'b0, 4'hF, '{4'hF, 4'h1, 4'h0, 4'h0}};
        for (int k = 15; k <= 19; k++) tbl[k] = '{1'b0, 4'hE, '{4'hF, 4'h0, 4'h0, 4'h0}};
        tbl[20] = '{1'b0, 4'hF, '{4'hF, 4'h0, 4'h0, 4'h1}};
        tbl[21] = '{1'b0, 4'hF, '{4'hF, 4'h0, 4'h0, 4'h0}};

        for (int k = 0; k < 22; k++)
            step(tbl[k].rst, tbl[k].in, $sformatf("tbl[%0d]", k), (LAT == 0), tbl[k].exp);
        for (int k = 0; k < LAT + 2; k++) step(1'b0, 4'hF, "settle0");

        // Channel 1: drive out[1] low, then 1x3, 0x1, 1x4 with a tail for latency.
        for (int k = 0; k < LO_TH + LAT + 2; k++) step(1'b0, 4'hD, "ch1_low");
        n_gl = 0;
        n_ri = 0;
        for (int k = 0; k < 8 + LAT + 2; k++) begin
            v = ((k == 3) || (k >= 4 + 4 + LAT + 2)) ? 4'hD : 4'hF;
            if (k == 3) v = 4'hD;
            step(1'b0, v, "ch1_seq");
            n_gl += int'(glitch[1]);
            n_ri += int'(rise[1]);
        end
        check_int("ch1_glitch_count", n_gl, 1);
        check_int("ch1_rise_count", n_ri, 1);

        // Channel 2: reset mid-run discards the partial count.
        for (int k = 0; k < 3; k++) step(1'b0, 4'hB, "ch2_part");
        step(1'b1, 4'hB, "ch2_rst");
        check_int("ch2_out_after_rst", int'(out[2]), 1);
        count_fall(2, "ch2_run", e_n);
        check_int("ch2_fall_edge", e_n, LO_TH + LAT);

        // All channels: independent random long-ish pulse trains.
        v = 4'hF;
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, i + 3) == 0) v[i] = ~v[i];
            step(1'b0, v, "random");
        end

        // Channel 0 fall latency from a clean reset.
        step(1'b1, 4'hF, "lat_rst");
        for (int k = 0; k < 4; k++) step(1'b0, 4'hF, "lat_idle");
        count_fall(0, "lat_run", e_n);
        check_int("ch0_fall_edge", e_n, LO_TH + LAT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debounce_multi.md
DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 Parameter CH, default 4, number of independent input channels (1..32).
REQ-002 Parameter CNT_W, default 4, width of each per-channel run-length counter.
REQ-003 Parameter HI_TH, default 4, consecutive high cycles needed to accept a rising level (1..2^CNT_W).
REQ-004 Parameter LO_TH, default 4, consecutive low cycles needed to accept a falling level (1..2^CNT_W).
REQ-005 Parameter INIT, default 1'b1, reset value of every out bit.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 in  input  CH  raw noisy inputs, one bit per channel.
REQ-009 out  output  CH  debounced level per channel, registered.
REQ-010 rise  output  CH  one-cycle pulse when out[i] goes 0->1, registered.
REQ-011 fall  output  CH  one-cycle pulse when out[i] goes 1->0, registered.
REQ-012 glitch  output  CH  one-cycle pulse when a candidate level change is rejected, registered.

Function
REQ-013 Each channel i SHALL be fully independent: own counter cnt[i], own out/rise/fall/glitch bits; no cross-channel interaction.
REQ-014 Sampled value s[i] SHALL be in[i] (or the synchroniser output, see REQ-026).
REQ-015 Threshold TH[i] SHALL be HI_TH when s[i]=1, LO_TH when s[i]=0.
REQ-016 If s[i]==out[i]: cnt[i] <= 0; glitch[i] <= 1 if cnt[i]!=0 else 0.
REQ-017 If s[i]!=out[i] and cnt[i]==TH[i]-1: out[i] <= s[i], cnt[i] <= 0, rise[i]/fall[i] asserted per direction in the same cycle out[i] changes.
REQ-018 If s[i]!=out[i] and cnt[i]<TH[i]-1: cnt[i] <= cnt[i]+1, out[i] held.
REQ-019 Latency: out[i] SHALL change on the TH-th consecutive rising edge at which s[i]!=out[i]; any differing run shorter than TH cycles SHALL leave out[i] unchanged and produce exactly one glitch[i] pulse on the edge after the run ends.
REQ-020 TH=1 SHALL yield a plain one-cycle registered copy of s[i] with no glitch pulses.
REQ-021 rise, fall, glitch SHALL each be high for exactly one cycle per event; rise[i] and fall[i] never simultaneously high; glitch[i] never high in the same cycle as rise[i] or fall[i].
REQ-022 cnt[i] SHALL never exceed TH[i]-1; no wrap-around is possible.
REQ-023 Asymmetric thresholds SHALL apply independently per direction (e.g. HI_TH=4, LO_TH=6).

Reset
REQ-024 While rst=1 at a rising edge: out <= {CH{INIT}}, cnt <= 0, rise <= 0, fall <= 0, glitch <= 0, synchroniser flops <= {CH{INIT}}; no pulses generated from reset release.
REQ-025 Reset asserted mid-count SHALL discard the partial run; counting restarts from 0 on the first non-reset edge.

Configuration
REQ-026 Macro DEBOUNCE_SYNC_EN defined: a 2-flop synchroniser per channel precedes the filter, s[i] is its second-stage output, latency increases by exactly 2 cycles; undefined: s[i]=in[i] directly, no extra flops.

Verification
REQ-027 CH=4, HI_TH=4, LO_TH=6, INIT=1, no sync: reset 3 cycles -> out=4'hF, rise=fall=glitch=0 throughout and first cycle after.
REQ-028 in[0]=0 held 6 cycles -> out[0] falls on 6th edge, fall[0]=1 for one cycle, cnt cleared; in[0]=0 held 5 cycles then 1 -> out[0] stays 1, glitch[0]=1 one cycle after.
REQ-029 From out[1]=0, in[1]=1 for 3 cycles, 0 for 1, 1 for 4 -> one glitch[1] pulse, then out[1]=1 with rise[1] on 4th edge of the final run.
REQ-030 Different pulse trains on all 4 channels simultaneously -> each channel matches an independent reference model; no cross-talk.
REQ-031 rst asserted at cnt[2]=3 of a 6-cycle low run -> out[2]=1 after reset, full 6 new low cycles required before fall[2].
REQ-032 DEBOUNCE_SYNC_EN defined, repeat REQ-028 -> out[0] falls exactly 2 cycles later than without macro.
